// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/prefetch path.
// A fetch entry pairs a returned instruction word with the byte PC it was fetched from.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries with a registered head.
// The head holds its last value when the queue empties or is flushed.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [31:0]            push_pc,
    input  logic [INSTR_W-1:0]     push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            head_pc,
    output logic [INSTR_W-1:0]     head_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head_q;
    fetch_entry_t     head_next;
    fetch_entry_t     push_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             do_push;
    logic             do_pop;

    assign push_entry = '{pc: push_pc, instr: push_instr};
    assign do_push    = push && !flush;
    assign do_pop     = pop && !flush && (count != '0);
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign head_pc    = head_q.pc;
    assign head_instr = head_q.instr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // The next head is either the entry behind the current head or a word
    // pushed straight into an empty (or emptying) queue.
    always_comb begin
        head_next = head_q;
        if (do_pop) begin
            if (count > CNT_W'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (do_push) begin
                head_next = push_entry;
            end
        end else if ((count == '0) && do_push) begin
            head_next = push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            head_q <= head_next;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction ROM initiator: issues word addresses, captures 1-cycle read data into a
// prefetch queue, and serves it downstream via valid/ready with redirect support.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
)
(
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_dout,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pc;
    logic [31:0]      inflight_pc;
    logic [31:0]      redirect_target;
    logic             inflight;
    logic             issue_fire;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] credit_used;

    assign rom_addr        = pc[ADDR_W+1:2];
    assign redirect_target = redirect_pc & ~32'h3;

    // A fetch is only issued when a queue slot is reserved for its response,
    // so the queue can never be written while full.
    assign credit_used = count + CNT_W'(inflight);
    assign issue_fire  = !redirect && (credit_used < CNT_W'(DEPTH));
    assign push        = inflight && !redirect;
    assign pop         = out_valid && out_ready;
    assign out_valid   = (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_target;
            inflight <= 1'b0;
        end else if (issue_fire) begin
            pc          <= pc + PC_INC;
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_instr (rom_dout),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit against a 1-cycle registered-read ROM model
// whose word i holds 32'hA000_0000 + i; deliveries are checked through an expectation queue.
module tb_fetch_prefetch_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_dout;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc0;
        logic [31:0] instr0;
        logic [31:0] pc1;
        logic [31:0] instr1;
    } redirect_vec_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    redirect_vec_t vecs[5];
    int            errors = 0;
    int            checks = 0;
    bit            sb_enable = 0;

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rom_dout = 32'h0;
    always @(posedge clk) rom_dout <= 32'hA000_0000 + {22'b0, rom_addr};

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA000_0000 + ((pc >> 2) & 32'h0000_03FF);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Every accepted instruction must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && sb_enable && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_delivery: got pc %h, expected no delivery", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("sb_pc", out_pc, mon_e.pc);
                check_output("sb_instr", out_instr, mon_e.instr);
            end
        end
    end

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: start + 32'(4 * i), instr: rom_word(start + 32'(4 * i))});
        end
    endtask

    task automatic drain(input int max_cycles, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < max_cycles) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic reset_release(input logic ready);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        redirect  = 1'b0;
        out_ready = 1'b0;
        sb_enable = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_output("reset_valid", out_valid, 32'd0);
        check_output("reset_pc", out_pc, 32'd0);
        check_output("reset_instr", out_instr, 32'd0);
        check_output("reset_rom_addr", rom_addr, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = ready;
    endtask

    task automatic startup_check();
        int cycles;
        reset_release(1'b1);
        push_stream(32'h0, 8);
        sb_enable = 1'b1;
        @(posedge clk);
        #1;
        check_output("startup_e1_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("startup_e2_valid", out_valid, 32'd1);
        check_output("startup_e2_pc", out_pc, 32'h0);
        check_output("startup_e2_instr", out_instr, 32'hA000_0000);
        drain(20, cycles);
        check_output("stream_no_gaps", cycles, 32'd8);
    endtask

    task automatic apply_stimulus(input redirect_vec_t v);
        int cycles;
        exp_q.delete();
        exp_q.push_back('{pc: v.pc0, instr: v.instr0});
        exp_q.push_back('{pc: v.pc1, instr: v.instr1});
        sb_enable   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = v.target;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check_output("redir_flush_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("redir_e1_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("redir_e2_valid", out_valid, 32'd1);
        check_output("redir_first_pc", out_pc, v.pc0);
        check_output("redir_first_instr", out_instr, v.instr0);
        drain(10, cycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'hA000_0040, 32'h0000_0104, 32'hA000_0041};
        vecs[1] = '{32'h0000_0FFC, 32'h0000_0FFC, 32'hA000_03FF, 32'h0000_1000, 32'hA000_0000};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hA000_03FF, 32'h0000_0000, 32'hA000_0000};
        vecs[3] = '{32'h0000_002A, 32'h0000_0028, 32'hA000_000A, 32'h0000_002C, 32'hA000_000B};
        vecs[4] = '{32'h0000_1001, 32'h0000_1000, 32'hA000_0000, 32'h0000_1004, 32'hA000_0001};

        $display("[TB] startup stream");
        startup_check();

        $display("[TB] backpressure fill and release");
        reset_release(1'b0);
        sb_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_output("fill_valid", out_valid, 32'd1);
        check_output("fill_rom_addr", rom_addr, 32'd4);
        @(posedge clk);
        #1;
        check_output("fill_rom_addr_hold", rom_addr, 32'd4);
        check_output("fill_head_pc", out_pc, 32'h0);
        check_output("fill_head_instr", out_instr, 32'hA000_0000);
        push_stream(32'h0, 8);
        out_ready = 1'b1;
        drain(30, cycles);

        $display("[TB] redirect table");
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                reset_release(1'b0);
                repeat (4) @(posedge clk);
                #1;
            end else begin
                sb_enable = 1'b0;
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1;
            end
            apply_stimulus(vecs[i]);
        end

        $display("[TB] redirect while first response returns");
        reset_release(1'b1);
        @(posedge clk);
        #1;
        exp_q.delete();
        push_stream(32'h200, 2);
        sb_enable   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check_output("late_resp_dropped", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("late_resp_e1_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("late_resp_e2_valid", out_valid, 32'd1);
        check_output("late_resp_pc", out_pc, 32'h0000_0200);
        check_output("late_resp_instr", out_instr, 32'hA000_0080);
        drain(10, cycles);

        $display("[TB] back-to-back redirects");
        sb_enable = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        push_stream(32'h400, 2);
        sb_enable   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(posedge clk);
        #1;
        redirect_pc = 32'h0000_0400;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        check_output("b2b_flush_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("b2b_e1_valid", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_output("b2b_e2_valid", out_valid, 32'd1);
        check_output("b2b_pc", out_pc, 32'h0000_0400);
        check_output("b2b_instr", out_instr, 32'hA000_0100);
        drain(10, cycles);

        $display("[TB] reset mid-stream");
        reset_release(1'b0);
        repeat (3) @(posedge clk);
        #3;
        check_output("pre_reset_valid", out_valid, 32'd1);
        reset = 1'b1;
        #1;
        check_output("async_reset_valid", out_valid, 32'd0);
        check_output("async_reset_pc", out_pc, 32'd0);
        check_output("async_reset_instr", out_instr, 32'd0);
        check_output("async_reset_rom_addr", rom_addr, 32'd0);
        startup_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
